// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA timing driver.
package vga_timing_pkg;

    // Region of one scan axis, visited in declaration order.
    typedef enum logic [1:0] {
        REG_ACT,
        REG_FP,
        REG_SYNC,
        REG_BP
    } vga_region_t;

    // Control bits carried through the renderer-latency delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_ctl_t;

    // Blanked, no sync asserted: the value after reset and in flushed delay stages.
    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Total ticks (or lines) of one axis period.
    function automatic logic [10:0] axis_total(input int act, input int fp,
                                               input int sync, input int bp);
        return 11'(act + fp + sync + bp);
    endfunction

    function automatic logic [10:0] h_total(input int act, input int fp,
                                            input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

    function automatic logic [10:0] v_total(input int act, input int fp,
                                            input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter plus the ACT->FP->SYNC->BP region FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step,
    output logic [10:0] o_cnt,
    output vga_region_t o_region,
    output logic        o_wrap
);

    // Last counter value of each region; transitions compare the counter against these.
    localparam logic [10:0] ACT_END   = 11'(ACTIVE - 1);
    localparam logic [10:0] FP_END    = 11'(ACTIVE + FP - 1);
    localparam logic [10:0] SYNC_END  = 11'(ACTIVE + FP + SYNC - 1);
    localparam logic [10:0] TOTAL_END = axis_total(ACTIVE, FP, SYNC, BP) - 11'd1;

    logic [10:0] cnt_q, cnt_d;
    vga_region_t region_q, region_d;

    // Next counter value and region, advancing only on a step.
    always_comb begin
        cnt_d    = cnt_q;
        region_d = region_q;
        if (i_step) begin
            cnt_d = (cnt_q == TOTAL_END) ? 11'd0 : cnt_q + 11'd1;
            case (region_q)
                REG_ACT:  if (cnt_q == ACT_END)   region_d = REG_FP;
                REG_FP:   if (cnt_q == FP_END)    region_d = REG_SYNC;
                REG_SYNC: if (cnt_q == SYNC_END)  region_d = REG_BP;
                REG_BP:   if (cnt_q == TOTAL_END) region_d = REG_ACT;
                default:  region_d = REG_ACT;
            endcase
        end
    end

    // State register with asynchronous reset to the start of the active region.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= 11'd0;
            region_q <= REG_ACT;
        end else begin
            cnt_q    <= cnt_d;
            region_q <= region_d;
        end
    end

    assign o_cnt    = cnt_q;
    assign o_region = region_q;
    assign o_wrap   = (cnt_q == TOTAL_END);

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing master: issues pixel coordinates, realigns sync/blank with the
// renderer's pipelined colour and registers everything towards the DAC.
module vga_timing_driver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int RGB_LAT  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    output logic [10:0] o_VGA_X,
    output logic [10:0] o_VGA_Y,
    output logic        o_frame_start,
    input  logic [7:0]  i_VGA_R,
    input  logic [7:0]  i_VGA_G,
    input  logic [7:0]  i_VGA_B,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        o_VGA_SYNC_N
);

    logic        h_wrap, v_wrap, v_step;
    vga_region_t h_region, v_region;
    vga_ctl_t    ctl_raw, ctl_tail;

    // The vertical axis advances once per line, on the tick that ends the line.
    assign v_step = i_pix_en && h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
    ) u_h_axis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (i_pix_en),
        .o_cnt    (o_VGA_X),
        .o_region (h_region),
        .o_wrap   (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
    ) u_v_axis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_step   (v_step),
        .o_cnt    (o_VGA_Y),
        .o_region (v_region),
        .o_wrap   (v_wrap)
    );

    // Undelayed control derived from the coordinates currently being issued.
    always_comb begin
        ctl_raw.hs      = (h_region != REG_SYNC);
        ctl_raw.vs      = (v_region != REG_SYNC);
        ctl_raw.blank_n = (h_region == REG_ACT) && (v_region == REG_ACT);
    end

    // Delay line so control reaches the output register together with the renderer colour.
    generate
        if (RGB_LAT == 0) begin : g_no_dly
            assign ctl_tail = ctl_raw;
        end else begin : g_dly
            vga_ctl_t dly_q [RGB_LAT];
            vga_ctl_t dly_d [RGB_LAT];

            // Shift by one stage per pixel tick.
            always_comb begin
                for (int i = 0; i < RGB_LAT; i++) begin
                    dly_d[i] = dly_q[i];
                end
                if (i_pix_en) begin
                    dly_d[0] = ctl_raw;
                    for (int i = 1; i < RGB_LAT; i++) begin
                        dly_d[i] = dly_q[i - 1];
                    end
                end
            end

            for (genvar gi = 0; gi < RGB_LAT; gi++) begin : g_stage
                // Stage register, flushed to the idle control value on reset.
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        dly_q[gi] <= CTL_IDLE;
                    end else begin
                        dly_q[gi] <= dly_d[gi];
                    end
                end
            end

            assign ctl_tail = dly_q[RGB_LAT - 1];
        end
    endgenerate

    vga_ctl_t   ctl_q, ctl_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       frame_start_q, frame_start_d;

    // Output register: load on a pixel tick; colour is zeroed while blanked.
    always_comb begin
        ctl_d         = ctl_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        frame_start_d = i_pix_en && h_wrap && v_wrap;
        if (i_pix_en) begin
            ctl_d = ctl_tail;
            r_d   = ctl_tail.blank_n ? i_VGA_R : 8'd0;
            g_d   = ctl_tail.blank_n ? i_VGA_G : 8'd0;
            b_d   = ctl_tail.blank_n ? i_VGA_B : 8'd0;
        end
    end

    // DAC-side registers with asynchronous reset to blanked, no sync.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctl_q         <= CTL_IDLE;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            ctl_q         <= ctl_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_VGA_HS      = ctl_q.hs;
    assign o_VGA_VS      = ctl_q.vs;
    assign o_VGA_BLANK_N = ctl_q.blank_n;
    assign o_VGA_R       = r_q;
    assign o_VGA_G       = g_q;
    assign o_VGA_B       = b_q;
    assign o_frame_start = frame_start_q;
    assign o_VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Scoreboard bench for vga_timing_driver: full horizontal timing, shortened
// vertical timing so several frames fit in a short run.
module tb_vga_timing_driver;

    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 6,   VF = 2,  VSW = 2,  VB = 3;
    localparam int LAT   = 1;
    localparam int HT    = HA + HF + HSW + HB;
    localparam int VT    = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pins_t;

    localparam pins_t PINS_IDLE = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 8'd0, g: 8'd0, b: 8'd0};

    logic        i_clk, i_rst, i_pix_en;
    logic [10:0] o_VGA_X, o_VGA_Y;
    logic        o_frame_start;
    logic [7:0]  i_VGA_R, i_VGA_G, i_VGA_B;
    logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;
    logic        o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N;

    vga_timing_driver #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .RGB_LAT  (LAT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pix_en      (i_pix_en),
        .o_VGA_X       (o_VGA_X),
        .o_VGA_Y       (o_VGA_Y),
        .o_frame_start (o_frame_start),
        .i_VGA_R       (i_VGA_R),
        .i_VGA_G       (i_VGA_G),
        .i_VGA_B       (i_VGA_B),
        .o_VGA_R       (o_VGA_R),
        .o_VGA_G       (o_VGA_G),
        .o_VGA_B       (o_VGA_B),
        .o_VGA_HS      (o_VGA_HS),
        .o_VGA_VS      (o_VGA_VS),
        .o_VGA_BLANK_N (o_VGA_BLANK_N),
        .o_VGA_SYNC_N  (o_VGA_SYNC_N)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_x"},  int'(o_VGA_X), 0);
        check_val({tag, "_y"},  int'(o_VGA_Y), 0);
        check_val({tag, "_hs"}, int'(o_VGA_HS), 1);
        check_val({tag, "_vs"}, int'(o_VGA_VS), 1);
        check_val({tag, "_bn"}, int'(o_VGA_BLANK_N), 0);
        check_val({tag, "_r"},  int'(o_VGA_R), 0);
        check_val({tag, "_g"},  int'(o_VGA_G), 0);
        check_val({tag, "_b"},  int'(o_VGA_B), 0);
        check_val({tag, "_fs"}, int'(o_frame_start), 0);
    endtask

    // Expected DAC pins for one coordinate, given the bench renderer below.
    function automatic pins_t model_pins(input int x, input int y);
        pins_t       p;
        logic [31:0] xv, yv;
        xv   = x;
        yv   = y;
        p.hs = !(x >= HA + HF && x < HA + HF + HSW);
        p.vs = !(y >= VA + VF && y < VA + VF + VSW);
        p.bn = (x < HA) && (y < VA);
        p.r  = p.bn ? xv[7:0] : 8'd0;
        p.g  = p.bn ? yv[7:0] : 8'd0;
        p.b  = p.bn ? 8'hA5 : 8'd0;
        return p;
    endfunction

    // Renderer with one tick of latency: colour from the coordinate issued one tick earlier.
    always @(posedge i_clk) begin
        if (i_rst) begin
            i_VGA_R <= 8'd0;
            i_VGA_G <= 8'd0;
            i_VGA_B <= 8'd0;
        end else if (i_pix_en) begin
            i_VGA_R <= o_VGA_X[7:0];
            i_VGA_G <= o_VGA_Y[7:0];
            i_VGA_B <= 8'hA5;
        end
    end

    // Reference model: own coordinates, expected pins pushed per tick and popped after the pipeline.
    int    mx, my;
    pins_t exp_q[$];
    pins_t cur_exp;
    logic  fs_exp;
    logic  adv;

    always @(posedge i_clk) begin
        if (i_rst) begin
            mx = 0;
            my = 0;
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back(PINS_IDLE);
            cur_exp = PINS_IDLE;
            fs_exp  = 1'b0;
            adv     = 1'b0;
        end else if (i_pix_en) begin
            exp_q.push_back(model_pins(mx, my));
            cur_exp = exp_q.pop_front();
            fs_exp  = (mx == HT - 1) && (my == VT - 1);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            adv = 1'b1;
        end else begin
            fs_exp = 1'b0;
            adv    = 1'b0;
        end
    end

    // Monitor on the falling edge: per-cycle comparison plus pulse-width and period checks.
    bit mode_tog;
    bit last_tog;
    bit fs_have;
    int hs_run, bn_run, vs_run, fs_ticks, fs_clks;

    always @(negedge i_clk) begin
        if (i_rst) begin
            hs_run   = 0;
            bn_run   = 0;
            vs_run   = 0;
            fs_ticks = 0;
            fs_clks  = 0;
            fs_have  = 1'b1;
            last_tog = mode_tog;
        end else begin
            check_val("x",      int'(o_VGA_X), mx);
            check_val("y",      int'(o_VGA_Y), my);
            check_val("hs",     int'(o_VGA_HS), int'(cur_exp.hs));
            check_val("vs",     int'(o_VGA_VS), int'(cur_exp.vs));
            check_val("blank_n", int'(o_VGA_BLANK_N), int'(cur_exp.bn));
            check_val("r",      int'(o_VGA_R), int'(cur_exp.r));
            check_val("g",      int'(o_VGA_G), int'(cur_exp.g));
            check_val("b",      int'(o_VGA_B), int'(cur_exp.b));
            check_val("frame_start", int'(o_frame_start), int'(fs_exp));
            check_val("sync_n", int'(o_VGA_SYNC_N), 0);

            if (mode_tog != last_tog) begin
                fs_have  = 1'b0;
                last_tog = mode_tog;
            end
            fs_clks++;
            if (adv) fs_ticks++;
            if (o_frame_start) begin
                if (fs_have) begin
                    check_val("frame_ticks", fs_ticks, FRAME);
                    check_val("frame_clks", fs_clks, mode_tog ? 2 * FRAME : FRAME);
                end
                fs_have  = 1'b1;
                fs_ticks = 0;
                fs_clks  = 0;
            end

            if (adv) begin
                if (!o_VGA_HS) begin
                    if (hs_run == 0) check_val("hs_start_x", int'(o_VGA_X), HA + HF + LAT + 1);
                    hs_run++;
                end else if (hs_run != 0) begin
                    check_val("hs_width", hs_run, HSW);
                    hs_run = 0;
                end
                if (o_VGA_BLANK_N) begin
                    bn_run++;
                end else if (bn_run != 0) begin
                    check_val("blank_width", bn_run, HA);
                    bn_run = 0;
                end
                if (!o_VGA_VS) begin
                    if (vs_run == 0) begin
                        check_val("vs_start_y", int'(o_VGA_Y), VA + VF);
                        check_val("vs_start_x", int'(o_VGA_X), LAT + 1);
                    end
                    vs_run++;
                end else if (vs_run != 0) begin
                    check_val("vs_width", vs_run, VSW * HT);
                    vs_run = 0;
                end
            end
        end
    end

    // Stimulus: reset, free-running frame, gated pixel clock, mid-frame reset.
    initial begin
        bit found;
        i_rst    = 1'b1;
        i_pix_en = 1'b1;
        mode_tog = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset("rst_hold");
        #2 i_rst = 1'b0;

        repeat (FRAME + 100) @(negedge i_clk);

        #2 mode_tog = 1'b1;
        repeat (4 * FRAME + 200) begin
            i_pix_en = ~i_pix_en;
            @(negedge i_clk);
            #2;
        end
        i_pix_en = 1'b1;
        mode_tog = 1'b0;

        found = 1'b0;
        for (int i = 0; i < FRAME + 100 && !found; i++) begin
            @(negedge i_clk);
            if (o_VGA_X == 11'd300 && o_VGA_Y == 11'd3) found = 1'b1;
        end
        check_val("reach_mid_frame", int'(found), 1);
        #2 i_rst = 1'b1;
        #1 check_reset("async_rst");
        repeat (2) @(negedge i_clk);
        check_reset("rst_hold2");
        #2 i_rst = 1'b0;
        repeat (FRAME + 100) @(negedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
